apb4_mem_slave: RTL and testbench
=================================

APB4_MEM_SLAVE -- requirements
Module: apb4_mem_slave

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, PWDATA/PRDATA width; legal values 8, 16, 32, 64.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 12, PADDR width in bytes.
REQ-003 SHALL provide parameter DEPTH, default 256, number of DATA_WIDTH words; DEPTH*DATA_WIDTH/8 <= 2**ADDR_WIDTH.
REQ-004 SHALL provide parameter WAIT_STATES, default 1, PREADY-low cycles per access; legal range 0..7.
REQ-005 SHALL provide parameter RO_WORDS, default 0, count of write-protected words starting at word index 0.
REQ-006 pclk  input  1  sole clock; all state on rising edge.
REQ-007 preset  input  1  reset, synchronous, active-high.
REQ-008 psel  input  1  slave select.
REQ-009 penable  input  1  access phase indicator.
REQ-010 pwrite  input  1  1 = write, 0 = read.
REQ-011 paddr  input  ADDR_WIDTH  byte address.
REQ-012 pwdata  input  DATA_WIDTH  write data.
REQ-013 pstrb  input  DATA_WIDTH/8  write byte strobes.
REQ-014 prdata  output  DATA_WIDTH  read data.
REQ-015 pready  output  1  transfer complete.
REQ-016 pslverr  output  1  transfer error, valid only with pready.

Function
REQ-017 SHALL implement FSM states IDLE and ACCESS; IDLE -> ACCESS on an edge sampling psel=1, penable=0.
REQ-018 ACCESS -> IDLE on an edge sampling psel=1, penable=1, pready=1 (completion); ACCESS -> IDLE with no side effect on an edge sampling psel=0 (abort).
REQ-019 Wait counter SHALL clear to 0 on IDLE->ACCESS, increment each ACCESS cycle while below WAIT_STATES, then saturate.
REQ-020 pready SHALL equal (state==ACCESS && psel && penable && count==WAIT_STATES); 0 in IDLE.
REQ-021 Word index = paddr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]; low byte-offset bits nonzero = misaligned.
REQ-022 Error condition, registered on IDLE->ACCESS edge: index >= DEPTH, or misaligned, or (pwrite and index < RO_WORDS).
REQ-023 pslverr SHALL equal pready AND registered error; 0 at all other times.
REQ-024 Read: memory word captured into prdata on IDLE->ACCESS edge; prdata held until next capture; erroring read captures all-zero.
REQ-025 Write: on completion edge with no error, byte i updated from pwdata[8i+7:8i] only where pstrb[i]=1; pstrb ignored on reads.
REQ-026 Erroring or aborted write SHALL leave memory unchanged.
REQ-027 Completion latency: WAIT_STATES+1 access-phase cycles; WAIT_STATES=0 gives zero-wait APB.
REQ-028 Back-to-back transfers (setup phase immediately after completion) SHALL be accepted with no idle cycle.
REQ-029 penable=1 sampled in IDLE SHALL be ignored (no transition, no error).

Reset
REQ-030 While preset=1 at an edge: state=IDLE, count=0, prdata=0, error flag=0; hence pready=0, pslverr=0.
REQ-031 Memory contents SHALL NOT be reset (RAM-inferable); reads before first write return undefined data.
REQ-032 Reset asserted mid-ACCESS SHALL abort the transfer without committing the write.

Structure
REQ-033 Shared package apb_pkg SHALL hold state enum (IDLE, ACCESS) and strobe-width/offset-bit constant functions.
REQ-034 Byte-enabled synchronous-read array SHALL be sub-module apb4_mem_array (write enable, byte enables, read index, registered read data).
REQ-035 Error decode, FSM and wait counter SHALL remain in apb4_mem_slave.

Verification
REQ-036 WAIT_STATES=1: write 0xDEADBEEF to 0x010, pstrb=0xF -> pready high 2nd access cycle, pslverr=0; read 0x010 -> prdata=0xDEADBEEF.
REQ-037 Strobes: after 0x11223344 at 0x020, write 0xAABBCCDD pstrb=0x5 -> read returns 0x11BB33DD.
REQ-038 DEPTH=256, write to 0x400 and to misaligned 0x013 -> pslverr=1 with pready; memory unchanged; read 0x400 -> prdata=0, pslverr=1.
REQ-039 RO_WORDS=4: write 0x12345678 to 0x008 -> pslverr=1, prior contents of 0x008 retained; read 0x008 -> pslverr=0.
REQ-040 Abort: psel dropped in 1st access cycle of write to 0x030 (WAIT_STATES=3) -> IDLE, no pready, memory unchanged; preset mid-ACCESS -> pready=0, prdata=0 next cycle.
REQ-041 WAIT_STATES=0, back-to-back write then read of 0x040 -> each completes in one access cycle, read returns written value.

Source files
------------

// File: rtl/apb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : apb_pkg                                                      |
// | Description : Shared FSM state type and width helpers for the APB4 memory  |
// |               slave and its storage array.                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package apb_pkg;

  // Transfer FSM: IDLE waits for a setup phase, ACCESS runs the access phase.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  // The wait counter only needs to reach the largest legal WAIT_STATES (7).
  localparam int unsigned c_wait_cnt_w = 3;

  // Number of byte lanes in a data word.
  function automatic int unsigned strb_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // Number of low address bits that select a byte inside a word.
  function automatic int unsigned off_bits(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  // Index width for a memory of 'depth' words; never narrower than one bit.
  function automatic int unsigned idx_bits(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb4_mem_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : apb4_mem_array                                               |
// | Description : Byte-enabled, single-clock storage array with a registered   |
// |               synchronous read port. Contents are not reset so the array   |
// |               maps onto block RAM.                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module apb4_mem_array
  import apb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned IDX_BITS   = 8
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  input  logic [IDX_BITS-1:0]     wr_idx,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic [IDX_BITS-1:0]     rd_idx,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  localparam int unsigned c_strb_w = strb_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Byte-lane write: only lanes with their enable set are updated.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < c_strb_w; i++) begin
        if (byte_en[i]) begin
          r_mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Registered read: the output holds until the next enabled read.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      r_rd_data <= r_mem[rd_idx];
    end
  end

  assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/apb4_mem_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : apb4_mem_slave                                               |
// | Description : APB4 completer backed by a byte-enabled memory. Fixed number |
// |               of wait states, address/alignment/write-protect error        |
// |               decode, abort on psel drop.                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module apb4_mem_slave
  import apb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned RO_WORDS    = 0
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int unsigned c_off_w = off_bits(DATA_WIDTH);
  localparam int unsigned c_idx_w = ADDR_WIDTH - c_off_w;
  localparam int unsigned c_mem_w = idx_bits(DEPTH);

  localparam logic [c_idx_w:0]        c_depth    = DEPTH[c_idx_w:0];
  localparam logic [c_idx_w:0]        c_ro_words = RO_WORDS[c_idx_w:0];
  localparam logic [c_wait_cnt_w-1:0] c_wait     = WAIT_STATES[c_wait_cnt_w-1:0];

  apb_state_e              r_state;
  apb_state_e              w_next_state;
  logic [c_wait_cnt_w-1:0] r_count;
  logic                    r_err;
  logic                    r_write;
  logic [c_mem_w-1:0]      r_idx;
  logic                    r_rd_zero;

  logic                    w_setup;
  logic                    w_complete;
  logic                    w_pready;
  logic [c_idx_w-1:0]      w_idx;
  logic                    w_misaligned;
  logic                    w_out_of_range;
  logic                    w_protected;
  logic                    w_err;
  logic                    w_mem_we;
  logic                    w_mem_re;
  logic [c_mem_w-1:0]      w_rd_idx;
  logic [DATA_WIDTH-1:0]   w_mem_rdata;

  // ---------------------------------------------------------------------------
  // Address decode, evaluated during the setup phase
  // ---------------------------------------------------------------------------
  assign w_idx = paddr[ADDR_WIDTH-1:c_off_w];

  generate
    if (c_off_w > 0) begin : g_align_chk
      assign w_misaligned = |paddr[c_off_w-1:0];
    end else begin : g_no_align_chk
      assign w_misaligned = 1'b0;
    end

    // When the memory fills the whole index space no index can be out of range.
    if (DEPTH < (2 ** c_idx_w)) begin : g_range_chk
      assign w_out_of_range = ({1'b0, w_idx} >= c_depth);
    end else begin : g_no_range_chk
      assign w_out_of_range = 1'b0;
    end

    if (RO_WORDS > 0) begin : g_ro_chk
      assign w_protected = pwrite && ({1'b0, w_idx} < c_ro_words);
    end else begin : g_no_ro_chk
      assign w_protected = 1'b0;
    end
  endgenerate

  assign w_err = w_out_of_range || w_misaligned || w_protected;

  // ---------------------------------------------------------------------------
  // Transfer FSM
  // ---------------------------------------------------------------------------
  assign w_pready = (r_state == ACCESS) && psel && penable && (r_count == c_wait);

  // State register; reset returns to IDLE and thereby aborts any transfer.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; penable without a setup phase is ignored in IDLE.
  always_comb begin
    w_next_state = r_state;
    w_setup      = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      IDLE: begin
        if (psel && !penable) begin
          w_next_state = ACCESS;
          w_setup      = 1'b1;
        end
      end
      ACCESS: begin
        if (!psel) begin
          w_next_state = IDLE;
        end else if (penable && w_pready) begin
          w_next_state = IDLE;
          w_complete   = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Wait counter: cleared at setup, counts access cycles up to WAIT_STATES.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_count <= '0;
    end else if (w_setup) begin
      r_count <= '0;
    end else if ((r_state == ACCESS) && (r_count != c_wait)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Per-transfer context captured at the setup edge.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_err     <= 1'b0;
      r_write   <= 1'b0;
      r_idx     <= '0;
      r_rd_zero <= 1'b1;
    end else if (w_setup) begin
      r_err   <= w_err;
      r_write <= pwrite;
      r_idx   <= w_idx[c_mem_w-1:0];
      if (!pwrite) begin
        r_rd_zero <= w_err;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // Reads sample the array at setup; writes commit only on a clean completion.
  // Gating with preset keeps a reset-during-completion from committing.
  assign w_mem_re = w_setup && !pwrite && !w_err && !preset;
  assign w_mem_we = w_complete && r_write && !r_err && !preset;
  assign w_rd_idx = w_err ? '0 : w_idx[c_mem_w-1:0];

  apb4_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_BITS   (c_mem_w)
  ) u_mem (
    .clk     (pclk),
    .wr_en   (w_mem_we),
    .byte_en (pstrb),
    .wr_idx  (r_idx),
    .wr_data (pwdata),
    .rd_en   (w_mem_re),
    .rd_idx  (w_rd_idx),
    .rd_data (w_mem_rdata)
  );

  // The array read register is not reset, so reset and erroring reads are
  // forced to zero here instead.
  assign prdata  = r_rd_zero ? '0 : w_mem_rdata;
  assign pready  = w_pready;
  assign pslverr = w_pready && r_err;

endmodule
`default_nettype wire

// File: tb/tb_apb4_mem_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_apb4_mem_slave                                            |
// | Description : Self-checking bench for apb4_mem_slave. Two instances        |
// |               (multi-wait with write protection, zero-wait) share one APB  |
// |               driver; a word/byte model predicts every response.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_apb4_mem_slave;

  localparam int DW   = 32;
  localparam int AW   = 12;
  localparam int DEP  = 256;
  localparam int WS_A = 2;
  localparam int RO_A = 4;
  localparam int WS_B = 0;
  localparam int RO_B = 0;

  logic          pclk = 1'b0;
  logic          preset;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [3:0]    pstrb;
  int            dsel;

  logic          psel_a;
  logic          psel_b;
  logic [DW-1:0] prdata_a;
  logic [DW-1:0] prdata_b;
  logic          pready_a;
  logic          pready_b;
  logic          pslverr_a;
  logic          pslverr_b;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: word contents and which bytes have been written.
  logic [31:0] mem_m   [2][DEP];
  bit          known_m [2][DEP][4];

  always #5 pclk = ~pclk;

  assign psel_a  = psel && (dsel == 0);
  assign psel_b  = psel && (dsel == 1);
  assign prdata  = (dsel == 0) ? prdata_a  : prdata_b;
  assign pready  = (dsel == 0) ? pready_a  : pready_b;
  assign pslverr = (dsel == 0) ? pslverr_a : pslverr_b;

  apb4_mem_slave #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .DEPTH (DEP),
    .WAIT_STATES (WS_A), .RO_WORDS (RO_A)
  ) dut_a (
    .pclk (pclk), .preset (preset), .psel (psel_a), .penable (penable),
    .pwrite (pwrite), .paddr (paddr), .pwdata (pwdata), .pstrb (pstrb),
    .prdata (prdata_a), .pready (pready_a), .pslverr (pslverr_a)
  );

  apb4_mem_slave #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .DEPTH (DEP),
    .WAIT_STATES (WS_B), .RO_WORDS (RO_B)
  ) dut_b (
    .pclk (pclk), .preset (preset), .psel (psel_b), .penable (penable),
    .pwrite (pwrite), .paddr (paddr), .pwdata (pwdata), .pstrb (pstrb),
    .prdata (prdata_b), .pready (pready_b), .pslverr (pslverr_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic int ws_of(input int d);
    return (d == 0) ? WS_A : WS_B;
  endfunction

  function automatic int ro_of(input int d);
    return (d == 0) ? RO_A : RO_B;
  endfunction

  // Error rule: beyond memory, not word aligned, or a write to a protected word.
  function automatic bit err_of(input int d, input bit wr, input logic [AW-1:0] a);
    int idx;
    idx = int'(a) / 4;
    return (idx >= DEP) || ((int'(a) % 4) != 0) || (wr && (idx < ro_of(d)));
  endfunction

  // One complete transfer; returns at the negedge where pready is seen, so the
  // caller may start the next setup right after the completion edge.
  task automatic xfer(input int d, input bit wr, input logic [AW-1:0] a,
                      input logic [31:0] wd, input logic [3:0] st, input string tag);
    int          cyc;
    int          idx;
    bit          e;
    logic [31:0] mask;
    e   = err_of(d, wr, a);
    idx = int'(a) / 4;
    @(posedge pclk); #1;
    dsel = d; psel = 1'b1; penable = 1'b0; pwrite = wr;
    paddr = a; pwdata = wd; pstrb = st;
    @(posedge pclk); #1;
    penable = 1'b1;
    cyc = 1;
    @(negedge pclk);
    while (!pready && cyc <= 16) begin
      check({tag, " slverr-while-waiting"}, 32'(pslverr), 32'd0);
      @(negedge pclk);
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'(ws_of(d) + 1));
    check({tag, " pslverr"}, 32'(pslverr), 32'(e));
    if (!wr) begin
      if (e) begin
        check({tag, " rdata-err"}, prdata, 32'd0);
      end else begin
        mask = '0;
        for (int b = 0; b < 4; b++) if (known_m[d][idx][b]) mask[8*b +: 8] = 8'hFF;
        if (mask != 32'd0) check({tag, " rdata"}, prdata & mask, mem_m[d][idx] & mask);
      end
    end else if (!e) begin
      for (int b = 0; b < 4; b++) begin
        if (st[b]) begin
          mem_m[d][idx][8*b +: 8] = wd[8*b +: 8];
          known_m[d][idx][b]      = 1'b1;
        end
      end
    end
  endtask

  task automatic idle();
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Directed scenarios followed by randomized traffic on both instances.
  initial begin
    int          n;
    int          d;
    bit          wr;
    int          cls;
    logic [AW-1:0] a;
    for (int i = 0; i < 2; i++) for (int j = 0; j < DEP; j++) begin
      mem_m[i][j] = '0;
      for (int b = 0; b < 4; b++) known_m[i][j][b] = 1'b0;
    end

    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; dsel = 0;
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;
    @(negedge pclk);
    check("reset pready_a",  32'(pready_a),  32'd0);
    check("reset pslverr_a", 32'(pslverr_a), 32'd0);
    check("reset prdata_a",  prdata_a,       32'd0);
    check("reset pready_b",  32'(pready_b),  32'd0);
    check("reset pslverr_b", 32'(pslverr_b), 32'd0);
    check("reset prdata_b",  prdata_b,       32'd0);

    // Basic write/read and byte strobes.
    xfer(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, "wr010"); idle();
    xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, "rd010");
    check("rd010 literal", prdata, 32'hDEADBEEF); idle();
    xfer(0, 1'b1, 12'h020, 32'h11223344, 4'hF, "wr020"); idle();
    xfer(0, 1'b1, 12'h020, 32'hAABBCCDD, 4'h5, "wr020-strb"); idle();
    xfer(0, 1'b0, 12'h020, 32'h0, 4'hF, "rd020");
    check("rd020 literal", prdata, 32'h11BB33DD); idle();

    // Range, alignment and write-protect errors.
    xfer(0, 1'b1, 12'h400, 32'hFFFFFFFF, 4'hF, "wr400-oor"); idle();
    xfer(0, 1'b1, 12'h013, 32'hFFFFFFFF, 4'hF, "wr013-mis"); idle();
    xfer(0, 1'b0, 12'h400, 32'h0, 4'h0, "rd400-oor"); idle();
    xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, "rd010-after-err"); idle();
    xfer(0, 1'b1, 12'h008, 32'h12345678, 4'hF, "wr008-ro"); idle();
    xfer(0, 1'b0, 12'h008, 32'h0, 4'h0, "rd008-ro"); idle();

    // penable without setup in IDLE is ignored.
    @(posedge pclk); #1;
    dsel = 0; psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 12'h400;
    @(negedge pclk);
    check("idle-penable pready", 32'(pready), 32'd0);
    @(negedge pclk);
    check("idle-penable pslverr", 32'(pslverr), 32'd0);
    xfer(0, 1'b1, 12'h030, 32'h0BADF00D, 4'hF, "wr030"); idle();

    // Abort: psel dropped during the first access cycle of a write.
    @(posedge pclk); #1;
    dsel = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 12'h030; pwdata = 32'h55555555; pstrb = 4'hF;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b1;
    @(negedge pclk);
    check("abort pready-1", 32'(pready), 32'd0);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b1;
    repeat (WS_A + 1) begin
      @(negedge pclk);
      check("abort pready-after", 32'(pready), 32'd0);
    end
    idle();
    xfer(0, 1'b0, 12'h030, 32'h0, 4'h0, "rd030-after-abort"); idle();

    // Reset at the completion edge of a write: nothing is committed.
    xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, "rd010-pre-reset"); idle();
    @(posedge pclk); #1;
    dsel = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 12'h010; pwdata = 32'h12121212; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    n = 0;
    @(negedge pclk);
    while (!pready && n < 16) begin
      @(negedge pclk);
      n++;
    end
    check("rst-mid pready-before", 32'(pready), 32'd1);
    preset = 1'b1;
    @(negedge pclk);
    check("rst-mid pready", 32'(pready), 32'd0);
    check("rst-mid pslverr", 32'(pslverr), 32'd0);
    check("rst-mid prdata", prdata, 32'd0);
    preset = 1'b0; psel = 1'b0; penable = 1'b0;
    xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, "rd010-after-rst"); idle();

    // Zero-wait back-to-back write then read.
    xfer(1, 1'b1, 12'h040, 32'hCAFE1234, 4'hF, "b2b-wr040");
    xfer(1, 1'b0, 12'h040, 32'h0, 4'h0, "b2b-rd040");
    check("b2b rd040 literal", prdata, 32'hCAFE1234); idle();

    // Randomized traffic.
    for (int it = 0; it < 120; it++) begin
      d   = int'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      cls = int'($urandom_range(0, 5));
      case (cls)
        0, 1:    a = AW'($urandom_range(0, 15) * 4);
        2:       a = AW'($urandom_range(0, DEP - 1) * 4);
        3:       a = AW'($urandom_range(0, DEP - 1) * 4 + $urandom_range(1, 3));
        4:       a = AW'($urandom_range(DEP, 1023) * 4);
        default: a = AW'($urandom_range(0, 7) * 4);
      endcase
      xfer(d, wr, a, $urandom, 4'($urandom_range(0, 15)), "rand");
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();
    repeat (2) @(posedge pclk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
